// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner: walks a one-cold column, debounces a single key press
// and its release, and emits one key_valid strobe per press (no auto-repeat).
module keypad_scanner #(
   parameter int unsigned SCAN_DIV = 20000,
   parameter int unsigned DEB_CNT  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CW = $clog2(DEB_CNT + 1);
   localparam logic [DW-1:0] DwellMax = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CntMax   = CW'(DEB_CNT);

   typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

   state_e        state_q, state_d;
   logic [3:0]    row_meta_q, rs_q;
   logic [DW-1:0] dwell_q;
   logic [1:0]    ci_q, ci_d;
   logic [1:0]    cand_q, cand_d;
   logic [CW-1:0] match_q, match_d, match_inc;
   logic [CW-1:0] rel_q, rel_d, rel_inc;
   logic [3:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic          tick;
   logic          one_low;
   logic [1:0]    low_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta_q <= 4'hF;
         rs_q       <= 4'hF;
      end else begin
         row_meta_q <= row;
         rs_q       <= row_meta_q;
      end
   end

   // Sampling only on the last dwell count gives the row lines time to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell_q <= '0;
      end else if (dwell_q == DwellMax) begin
         dwell_q <= '0;
      end else begin
         dwell_q <= dwell_q + DW'(1);
      end
   end

   assign tick = (dwell_q == DwellMax);

   // Two or more low rows (ghosting / multi-press) is treated as no key.
   always_comb begin
      one_low = 1'b0;
      low_idx = 2'd0;
      case (rs_q)
         4'b1110: begin one_low = 1'b1; low_idx = 2'd0; end
         4'b1101: begin one_low = 1'b1; low_idx = 2'd1; end
         4'b1011: begin one_low = 1'b1; low_idx = 2'd2; end
         4'b0111: begin one_low = 1'b1; low_idx = 2'd3; end
         default: ;
      endcase
   end

   assign match_inc = match_q + CW'(1);
   assign rel_inc   = rel_q + CW'(1);

   always_comb begin
      state_d = state_q;
      ci_d    = ci_q;
      cand_d  = cand_q;
      match_d = match_q;
      rel_d   = rel_q;
      code_d  = code_q;
      valid_d = 1'b0;
      if (tick) begin
         case (state_q)
            StScan: begin
               if (one_low) begin
                  cand_d  = low_idx;
                  match_d = CW'(1);
                  state_d = StDebounce;
               end else begin
                  ci_d = ci_q + 2'd1;
               end
            end
            StDebounce: begin
               if (one_low && (low_idx == cand_q)) begin
                  if (match_inc == CntMax) begin
                     code_d  = {cand_q, ci_q};
                     valid_d = 1'b1;
                     match_d = '0;
                     rel_d   = '0;
                     state_d = StHeld;
                  end else begin
                     match_d = match_inc;
                  end
               end else begin
                  match_d = '0;
                  ci_d    = ci_q + 2'd1;
                  state_d = StScan;
               end
            end
            StHeld: begin
               if (rs_q == 4'hF) begin
                  if (rel_inc == CntMax) begin
                     rel_d   = '0;
                     ci_d    = ci_q + 2'd1;
                     state_d = StScan;
                  end else begin
                     rel_d = rel_inc;
                  end
               end else begin
                  rel_d = '0;
               end
            end
            default: state_d = StScan;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StScan;
         ci_q    <= 2'd0;
         cand_q  <= 2'd0;
         match_q <= '0;
         rel_q   <= '0;
         code_q  <= 4'h0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ci_q    <= ci_d;
         cand_q  <= cand_d;
         match_q <= match_d;
         rel_q   <= rel_d;
         code_q  <= code_d;
         valid_q <= valid_d;
      end
   end

   assign col       = ~(4'b0001 << ci_q);
   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = (state_q == StHeld);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner using a 4x4 switch-matrix model driven by a key bitmap.
module tb_keypad_scanner;

   logic        clk;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] keys;

   int n_cmp = 0;
   int n_bad = 0;
   int strobes = 0;
   int base;

   keypad_scanner #(
      .SCAN_DIV (8),
      .DEB_CNT  (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pressed key (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      if (key_valid) strobes <= strobes + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns just after col switches to target, i.e. with the dwell counter at 0.
   task automatic wait_col_entry(input logic [3:0] target, input string tag);
      int n;
      n = 0;
      while (col == target && n < 40) begin tick(1); n++; end
      n = 0;
      while (col != target && n < 40) begin tick(1); n++; end
      check(tag, col, target);
   endtask

   task automatic wait_release(input string tag);
      int n;
      n = 0;
      while (key_held && n < 40) begin tick(1); n++; end
      check(tag, key_held, 1'b0);
   endtask

   initial begin
      int trans;
      logic [3:0] prev;
      logic [3:0] exp_col;

      rst  = 1'b1;
      keys = 16'h0;
      tick(3);
      check("rst_col", col, 4'b1110);
      check("rst_code", key_code, 4'h0);
      check("rst_valid", key_valid, 1'b0);
      check("rst_held", key_held, 1'b0);

      // Reset and idle: column walks every 8 cycles.
      rst = 1'b0;
      for (int k = 0; k <= 40; k++) begin
         exp_col = ~(4'b0001 << ((k / 8) % 4));
         check("idle_col", col, exp_col);
         tick(1);
      end
      check("idle_strobes", strobes, 0);
      check("idle_code", key_code, 4'h0);

      // Single key 9 (row2/col1).
      base = strobes;
      keys[9] = 1'b1;
      tick(100);
      check("k9_strobes", strobes - base, 1);
      check("k9_code", key_code, 4'h9);
      check("k9_held", key_held, 1'b1);
      keys[9] = 1'b0;
      tick(10);
      check("k9_held_after_rel", key_held, 1'b1);
      wait_release("k9_release");
      check("k9_strobes_end", strobes - base, 1);

      // Bounce on key F (row3/col3), aligned so col3 sees two pressed samples then a gap.
      wait_col_entry(4'b1011, "bnc_align");
      base = strobes;
      keys[15] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (i > 0 && i % 5 == 0) keys[15] = ~keys[15];
         tick(1);
      end
      keys[15] = 1'b1;
      check("bnc_no_strobe_bounce", strobes - base, 0);
      tick(30);
      check("bnc_no_strobe_settle", strobes - base, 0);
      check("bnc_not_held", key_held, 1'b0);
      tick(40);
      check("bnc_strobes", strobes - base, 1);
      check("bnc_code", key_code, 4'hF);
      check("bnc_held", key_held, 1'b1);
      keys[15] = 1'b0;
      wait_release("bnc_release");

      // Ghost: rows 0 and 2 low on column 0, scanning must keep going.
      base = strobes;
      keys[0] = 1'b1;
      keys[8] = 1'b1;
      trans = 0;
      prev = col;
      for (int i = 0; i < 80; i++) begin
         tick(1);
         if (col != prev) trans++;
         prev = col;
      end
      check("ghost_col_steps", trans, 10);
      check("ghost_strobes", strobes - base, 0);
      check("ghost_held", key_held, 1'b0);
      keys[0] = 1'b0;
      keys[8] = 1'b0;
      tick(10);

      // Hold 5, add 6, release 5: 6 reported once afterwards.
      base = strobes;
      keys[5] = 1'b1;
      tick(100);
      check("h5_strobes", strobes - base, 1);
      check("h5_code", key_code, 4'h5);
      keys[6] = 1'b1;
      tick(60);
      check("h6_ignored", strobes - base, 1);
      check("h6_code_keeps5", key_code, 4'h5);
      check("h6_held", key_held, 1'b1);
      keys[5] = 1'b0;
      wait_release("h5_release");
      tick(100);
      check("h6_strobes", strobes - base, 2);
      check("h6_code", key_code, 4'h6);
      check("h6_held_after", key_held, 1'b1);
      keys[6] = 1'b0;
      wait_release("h6_release");

      // Reset after two matching samples of key 3 (row0/col3).
      wait_col_entry(4'b0111, "rst3_align");
      base = strobes;
      keys[3] = 1'b1;
      tick(18);
      rst = 1'b1;
      #1;
      check("rst3_col", col, 4'b1110);
      check("rst3_code", key_code, 4'h0);
      check("rst3_held", key_held, 1'b0);
      tick(3);
      rst = 1'b0;
      check("rst3_no_strobe", strobes - base, 0);
      tick(100);
      check("rst3_strobes", strobes - base, 1);
      check("rst3_code_after", key_code, 4'h3);
      check("rst3_held_after", key_held, 1'b1);
      keys[3] = 1'b0;
      wait_release("rst3_release");

      check("total_strobes", strobes, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
